// File: rtl/nes_video_pkg.sv
// Shared frame-buffer geometry, pixel/colour types, write-FSM states and the
// 64-entry NES palette (2C02 approximation, 4 bits per channel, R[11:8] G[7:4] B[3:0]).
package nes_video_pkg;

  localparam int FB_W      = 256;
  localparam int FB_H      = 240;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int PIX_W     = 6;
  localparam int RGB_W     = 12;

  typedef logic [PIX_W-1:0] pix_idx_t;
  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_e;

  localparam rgb_t NES_PALETTE [64] = '{
    12'h666, 12'h028, 12'h109, 12'h309, 12'h407, 12'h503, 12'h500, 12'h310,
    12'h220, 12'h030, 12'h040, 12'h031, 12'h034, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h15E, 12'h43F, 12'h72F, 12'hA2C, 12'hB27, 12'hB31, 12'h950,
    12'h670, 12'h290, 12'h0A0, 12'h0A3, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h5AF, 12'h88F, 12'hB6F, 12'hF5F, 12'hF5B, 12'hF75, 12'hE92,
    12'hBB0, 12'h7D1, 12'h4E4, 12'h3E8, 12'h3CD, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hBDF, 12'hCCF, 12'hDBF, 12'hFBF, 12'hFBD, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hCEA, 12'hBFB, 12'hAFD, 12'hAEE, 12'hBBB, 12'h000, 12'h000
  };

  function automatic rgb_t paletteLookup(input pix_idx_t idx);
    return NES_PALETTE[idx];
  endfunction

endpackage

// File: rtl/fb_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
module fb_ram #(
  parameter int DEPTH = 61440,
  parameter int AW    = 16,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [DW-1:0] i_wrData,
  input  logic [AW-1:0] i_rdAddr,
  output logic [DW-1:0] o_rdData
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdData;

  // Write on enable, and always register the read word (contents are never reset).
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/ppu_frame_buffer.sv
// Double-buffered frame store: PPU fills the back bank, VGA reads the front bank
// through the palette. Banks swap only on a vsync falling edge after a complete frame.
// Until the first swap after reset the front bank holds no frame and reads return black.
module ppu_frame_buffer #(
  parameter int FB_W  = 256,
  parameter int FB_H  = 240,
  parameter int PIX_W = 6,
  parameter int RGB_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_frame_start,
  input  logic [19:0]      index,
  input  logic             vga_vsync,
  output logic [RGB_W-1:0] data_vga,
  output logic             frame_swapped,
  output logic             frame_dropped
);

  import nes_video_pkg::*;

  localparam int          NPIX   = FB_W * FB_H;
  localparam int          AW     = $clog2(NPIX);
  localparam logic [19:0] NPIX20 = 20'(NPIX);
  localparam logic [15:0] LAST16 = 16'(NPIX - 1);

  wr_state_e        r_state;
  wr_state_e        w_stateNext;
  logic [15:0]      r_wrPtr;
  logic [15:0]      w_wrPtrNext;
  logic             w_wrEn;
  logic [15:0]      w_wrAddr;
  logic             w_frameDone;
  logic             w_dropFrame;
  logic             w_swap;

  logic             r_wrBank;
  logic             r_swapPending;
  logic             r_frontValid;
  logic             r_vsyncSync;
  logic             r_vsyncHist;
  logic             r_vsyncFall;
  logic             r_frameSwapped;
  logic             r_frameDropped;

  logic             r_rdBlank;
  logic             r_rdSel;
  logic [RGB_W-1:0] r_dataVga;
  logic [PIX_W-1:0] w_q0;
  logic [PIX_W-1:0] w_q1;

  assign w_swap = r_vsyncFall & r_swapPending;

  // Write FSM next state: start/restart a frame on frame_start, finish on the last pixel.
  always_comb begin
    w_stateNext = r_state;
    w_wrPtrNext = r_wrPtr;
    w_wrEn      = 1'b0;
    w_wrAddr    = '0;
    w_frameDone = 1'b0;
    w_dropFrame = 1'b0;
    case (r_state)
      WR_IDLE: begin
        if (pix_valid && pix_frame_start) begin
          w_wrEn      = 1'b1;
          w_wrPtrNext = 16'd1;
          w_stateNext = WR_FILL;
        end
      end
      WR_FILL: begin
        if (pix_valid) begin
          w_wrEn = 1'b1;
          if (pix_frame_start) begin
            w_dropFrame = 1'b1;
            w_wrPtrNext = 16'd1;
          end else begin
            w_wrAddr    = r_wrPtr;
            w_wrPtrNext = r_wrPtr + 16'd1;
            if (r_wrPtr == LAST16) begin
              w_frameDone = 1'b1;
              w_wrPtrNext = '0;
              w_stateNext = WR_IDLE;
            end
          end
        end
      end
      default: w_stateNext = WR_IDLE;
    endcase
    if (w_swap) begin
      w_stateNext = WR_IDLE;
    end
  end

  // Write FSM state and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WR_IDLE;
      r_wrPtr <= '0;
    end else begin
      r_state <= w_stateNext;
      r_wrPtr <= w_wrPtrNext;
    end
  end

  // Vsync edge detect and bank swap; a frame finishing on the swap-decision cycle waits for the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsyncSync    <= 1'b1;
      r_vsyncHist    <= 1'b1;
      r_vsyncFall    <= 1'b0;
      r_swapPending  <= 1'b0;
      r_wrBank       <= 1'b0;
      r_frontValid   <= 1'b0;
      r_frameSwapped <= 1'b0;
      r_frameDropped <= 1'b0;
    end else begin
      r_vsyncSync    <= vga_vsync;
      r_vsyncHist    <= r_vsyncSync;
      r_vsyncFall    <= r_vsyncHist & ~r_vsyncSync;
      r_frameSwapped <= w_swap;
      r_frameDropped <= w_dropFrame;
      if (w_swap) begin
        r_wrBank      <= ~r_wrBank;
        r_swapPending <= 1'b0;
        r_frontValid  <= 1'b1;
      end else if (w_frameDone) begin
        r_swapPending <= 1'b1;
      end
    end
  end

  fb_ram #(.DEPTH(NPIX), .AW(AW), .DW(PIX_W)) u_bank0 (
    .clk      (clk),
    .i_wrEn   (w_wrEn & ~r_wrBank),
    .i_wrAddr (w_wrAddr[AW-1:0]),
    .i_wrData (pix_data),
    .i_rdAddr (index[AW-1:0]),
    .o_rdData (w_q0)
  );

  fb_ram #(.DEPTH(NPIX), .AW(AW), .DW(PIX_W)) u_bank1 (
    .clk      (clk),
    .i_wrEn   (w_wrEn & r_wrBank),
    .i_wrAddr (w_wrAddr[AW-1:0]),
    .i_wrData (pix_data),
    .i_rdAddr (index[AW-1:0]),
    .o_rdData (w_q1)
  );

  // Read pipeline: stage 1 registers bank select and blanking beside the RAM read, stage 2 the palette colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdBlank <= 1'b1;
      r_rdSel   <= 1'b0;
      r_dataVga <= '0;
    end else begin
      r_rdBlank <= (index >= NPIX20) || !r_frontValid;
      r_rdSel   <= ~r_wrBank;
      r_dataVga <= r_rdBlank ? '0 : paletteLookup(r_rdSel ? w_q1 : w_q0);
    end
  end

  assign data_vga      = r_dataVga;
  assign frame_swapped = r_frameSwapped;
  assign frame_dropped = r_frameDropped;

endmodule

// File: doc/ppu_frame_buffer.md
# ppu_frame_buffer

Double-buffered 256x240 frame store between the PPU pixel output and the VGA scan-out stage. Accepts one 6-bit NES palette index per valid cycle from the PPU and writes it into the back bank. Serves random reads by linear pixel index from the front bank, converting through a 64-entry NES palette to 12-bit RGB for the VGA stage. Banks swap only on a completed frame, aligned to the VGA vertical sync, so scan-out never shows a torn frame.

## Interface
Parameters:
- FB_W, 256, pixels per line
- FB_H, 240, lines per frame
- PIX_W, 6, PPU palette-index width
- RGB_W, 12, output colour width, R[11:8] G[7:4] B[3:0]

Ports:
- clk  in  1  system clock; the single clock for all logic
- rst  in  1  reset; synchronous, active-high
- pix_valid  in  1  PPU pixel strobe
- pix_data  in  PIX_W  NES palette index of the current pixel
- pix_frame_start  in  1  marks the first pixel of a frame; qualified by pix_valid
- index  in  20  VGA read address, linear pixel number (line*256 + column)
- vga_vsync  in  1  VGA vertical sync, active-low
- data_vga  out  RGB_W  RGB of the pixel addressed two cycles earlier
- frame_swapped  out  1  one-cycle pulse when the banks swap
- frame_dropped  out  1  one-cycle pulse when a partial frame is abandoned

## Operation
- Storage: two banks of 61440 x 6 bits. Reg wr_bank selects the back bank; the front bank is always ~wr_bank.
- Write pointer wr_ptr[15:0] and one state reg, IDLE or FILL.
  - IDLE: writes ignored. pix_valid & pix_frame_start -> write pix_data at address 0, wr_ptr=1, go to FILL.
  - FILL, pix_valid & ~pix_frame_start: write at wr_ptr, wr_ptr+1. The write at 61439 sets swap_pending=1 and goes to IDLE.
  - FILL, pix_valid & pix_frame_start: the partial frame is discarded. Pulse frame_dropped, write at 0, wr_ptr=1, stay in FILL. swap_pending is unchanged.
  - In IDLE with swap_pending=1, a new frame start overwrites the back bank. The pending swap stays armed.
- Swap: a vsync falling edge (registered vga_vsync 1 -> 0) with swap_pending=1 toggles wr_bank, clears swap_pending, pulses frame_swapped and forces state to IDLE.
  - A frame completing on the same cycle as the edge is not swapped until the next edge.
- Read path: index >= 61440 yields data_vga=0. Otherwise data_vga = palette[front_bank[index[15:0]]].
- The front bank is selected by the wr_bank value at the cycle index is sampled. A swap therefore takes effect for addresses presented after the swap cycle.

## Timing
- Reset values:
  - data_vga=0, frame_swapped=0, frame_dropped=0
  - wr_bank=0, wr_ptr=0, state=IDLE, swap_pending=0
  - vsync history register=1
  - Bank RAM contents are not reset.
- Write: pixel stored at the clk edge where pix_valid=1. A read of that address from the back bank is never possible.
- Read latency is exactly 2 cycles:
  - Stage 1: RAM read, with the out-of-range flag registered alongside.
  - Stage 2: palette lookup, registered into data_vga.
  - Fully pipelined, one read per cycle.
- Frame sequence from first pixel: frame_swapped rises 2 cycles after the first vga_vsync low sample following the final pixel write; it is high for 1 cycle.
- rst mid-frame: the write in progress is abandoned and wr_bank returns to 0. data_vga reads 0 on the cycle after rst is sampled, then resumes with 2-cycle latency.

## Structure
- Package nes_video_pkg:
  - FB_W, FB_H, FB_PIXELS=61440
  - 64-entry x 12-bit NES palette constant table
  - typedef for the pixel index (PIX_W) and for the rgb word
- Sub-module fb_ram: simple dual-port RAM, 1 write / 1 read port, registered read. Instantiated twice, or once as 122880 x 6 with the bank as address MSB.
- Top holds the write FSM, swap logic, vsync edge detector and read pipeline.

## Test plan
- Reset, then index=0..5 -> data_vga=0x000 for all, no pulses.
- Frame of 61440 pixels with pix_data = addr[5:0], then a vga_vsync 1->0 edge:
  - frame_swapped pulses once.
  - index=65 two cycles later -> data_vga = palette[1].
- Frame start after 1000 pixels, then a full frame of value 0x20 and a vsync edge:
  - frame_dropped pulses once.
  - All reads return palette[0x20].
- Completed frame with no vsync edge -> front bank unchanged, reads still return the previous frame.
- Final pixel written on the same cycle as a vsync edge -> no swap; swap on the next edge.
- index=61440 and index=0xFFFFF -> data_vga=0x000 two cycles later. Back-to-back reads of index 0,1,2 -> data on 3 consecutive cycles.
